// File: rtl/i2s_frame_ctrl.sv
// I2S frame controller: slot timing and lrclk generation, one-entry TX shadow
// buffer with underrun accounting, and capture of the looped-back RX frame.
module i2s_frame_ctrl #(
    parameter int AUDIO_DW = 24,
    parameter int SLOT_W   = 27,
    parameter int RX_LAT   = 1
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                en,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [AUDIO_DW-1:0] tx_left,
    input  logic [AUDIO_DW-1:0] tx_right,
    output logic                lrclk,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    input  logic [AUDIO_DW-1:0] rx_left_chan,
    input  logic [AUDIO_DW-1:0] rx_right_chan,
    output logic [AUDIO_DW-1:0] rx_left,
    output logic [AUDIO_DW-1:0] rx_right,
    output logic                rx_valid,
    output logic                underrun,
    output logic [7:0]          underrun_cnt,
    output logic                busy
);

    if (SLOT_W < AUDIO_DW + 1) begin : g_bad_slot_w
        $error("i2s_frame_ctrl: SLOT_W must be at least AUDIO_DW+1");
    end
    if (RX_LAT < 0 || RX_LAT >= SLOT_W) begin : g_bad_rx_lat
        $error("i2s_frame_ctrl: RX_LAT must lie in 0..SLOT_W-1");
    end

    localparam int CW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_W - 1);
    localparam logic [CW-1:0] CNT_CAP  = CW'(RX_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_L = 2'd1,
        RUN_R = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic                frame_start;
    logic                capture;
    logic                slot_r_end;
    logic                have_frame;
    logic                shadow_full;
    logic [AUDIO_DW-1:0] shadow_l, shadow_r;
    logic                handshake;

    assign tx_ready  = rst & ~shadow_full;
    assign handshake = tx_valid & tx_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        frame_start = 1'b0;
        capture     = 1'b0;
        slot_r_end  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (en) begin
                    state_nx    = RUN_L;
                    frame_start = 1'b1;
                end
            end
            RUN_L: begin
                capture = have_frame && (cnt == CNT_CAP);
                if (cnt == CNT_LAST) begin
                    state_nx = RUN_R;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RUN_R: begin
                if (cnt == CNT_LAST) begin
                    slot_r_end = 1'b1;
                    cnt_nx     = '0;
                    if (en) begin
                        state_nx    = RUN_L;
                        frame_start = 1'b1;
                    end else begin
                        state_nx = FLUSH;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            FLUSH: begin
                if (cnt == CNT_CAP) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(negedge sclk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(negedge sclk) begin
        if (!rst) begin
            lrclk        <= 1'b1;
            shadow_full  <= 1'b0;
            shadow_l     <= '0;
            shadow_r     <= '0;
            left_chan    <= '0;
            right_chan   <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            have_frame   <= 1'b0;
            rx_left      <= '0;
            rx_right     <= '0;
            rx_valid     <= 1'b0;
        end else begin
            lrclk    <= (state_nx != RUN_L);
            underrun <= frame_start & ~shadow_full;
            rx_valid <= capture;

            // A sample accepted on the frame-start edge only fills the shadow;
            // the outputs see it at the following frame start.
            if (frame_start) begin
                if (shadow_full) begin
                    left_chan  <= shadow_l;
                    right_chan <= shadow_r;
                end else begin
                    left_chan  <= '0;
                    right_chan <= '0;
                    if (underrun_cnt != 8'hFF)
                        underrun_cnt <= underrun_cnt + 8'd1;
                end
            end

            if (handshake) begin
                shadow_full <= 1'b1;
                shadow_l    <= tx_left;
                shadow_r    <= tx_right;
            end else if (frame_start) begin
                shadow_full <= 1'b0;
            end

            if (slot_r_end)
                have_frame <= 1'b1;
            else if (state == FLUSH && state_nx == IDLE)
                have_frame <= 1'b0;

            if (capture) begin
                rx_left  <= rx_left_chan;
                rx_right <= rx_right_chan;
            end
        end
    end

endmodule
